// File: rtl/ntt_intt_pkg.sv
// rtl/ntt_intt_pkg.sv - moduli, Barrett constants and encodings shared by the multiply-reduce datapath
package ntt_intt_pkg;

  localparam logic [63:0] Q0 = 64'd4293918721;
  localparam logic [63:0] Q1 = 64'd8380417;
  localparam logic [63:0] Q2 = 64'd12289;

  localparam logic [1:0] QSEL_Q0   = 2'd0;
  localparam logic [1:0] QSEL_Q1   = 2'd1;
  localparam logic [1:0] QSEL_Q2   = 2'd2;
  localparam logic [1:0] QSEL_RSVD = 2'd3;

  typedef enum logic {
    OP_MUL    = 1'b0,
    OP_MULADD = 1'b1
  } op_e;

  localparam int PIP_MIN = 4;
  localparam int PIP_MAX = 10;

  function automatic int unsigned bitlen(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  function automatic logic [63:0] barrett_mu(input logic [63:0] q);
    logic [127:0] num;
    num = 128'd1 << (2 * bitlen(q));
    return 64'(num / {64'd0, q});
  endfunction

  localparam logic [6:0]  K0  = 7'(bitlen(Q0));
  localparam logic [6:0]  K1  = 7'(bitlen(Q1));
  localparam logic [6:0]  K2  = 7'(bitlen(Q2));
  localparam logic [63:0] MU0 = barrett_mu(Q0);
  localparam logic [63:0] MU1 = barrett_mu(Q1);
  localparam logic [63:0] MU2 = barrett_mu(Q2);

  function automatic logic qsel_err(input logic [1:0] sel, input logic [2:0] q_en);
    case (sel)
      QSEL_Q0: return !q_en[0];
      QSEL_Q1: return !q_en[1];
      QSEL_Q2: return !q_en[2];
      default: return 1'b1;
    endcase
  endfunction

  // Disabled moduli fold to constant zero so their Barrett logic is trimmed away.
  function automatic logic [63:0] q_of(input logic [1:0] sel, input logic [2:0] q_en);
    if (qsel_err(sel, q_en)) return 64'd0;
    case (sel)
      QSEL_Q0: return Q0;
      QSEL_Q1: return Q1;
      default: return Q2;
    endcase
  endfunction

  function automatic logic [63:0] mu_of(input logic [1:0] sel, input logic [2:0] q_en);
    if (qsel_err(sel, q_en)) return 64'd0;
    case (sel)
      QSEL_Q0: return MU0;
      QSEL_Q1: return MU1;
      default: return MU2;
    endcase
  endfunction

  function automatic logic [6:0] k_of(input logic [1:0] sel, input logic [2:0] q_en);
    if (qsel_err(sel, q_en)) return 7'd1;
    case (sel)
      QSEL_Q0: return K0;
      QSEL_Q1: return K1;
      default: return K2;
    endcase
  endfunction

endpackage

// File: rtl/mulred_pipe_if.sv
// rtl/mulred_pipe_if.sv - handshaked operand/result bus of the multiply-reduce unit
interface mulred_pipe_if #(
  parameter int COE_WIDTH = 39,
  parameter int LANES     = 1,
  parameter int TAG_WIDTH = 8
);
  logic                         i_valid;
  logic                         o_ready;
  logic [1:0]                   i_q_sel;
  logic                         i_op;
  logic [LANES*COE_WIDTH-1:0]   i_a;
  logic [LANES*COE_WIDTH-1:0]   i_b;
  logic [LANES*COE_WIDTH-1:0]   i_c;
  logic [TAG_WIDTH-1:0]         i_tag;
  logic                         o_valid;
  logic                         i_ready;
  logic [LANES*COE_WIDTH-1:0]   o_mulred;
  logic [TAG_WIDTH-1:0]         o_tag;
  logic                         o_err;

  modport slave (
    input  i_valid, i_q_sel, i_op, i_a, i_b, i_c, i_tag, i_ready,
    output o_ready, o_valid, o_mulred, o_tag, o_err
  );

  modport master (
    output i_valid, i_q_sel, i_op, i_a, i_b, i_c, i_tag, i_ready,
    input  o_ready, o_valid, o_mulred, o_tag, o_err
  );
endinterface

// File: rtl/barrett_lane.sv
// rtl/barrett_lane.sv - one lane of addend merge, Barrett estimate and final correction (3 stages)
module barrett_lane
  import ntt_intt_pkg::*;
#(
  parameter int         COE_WIDTH = 39,
  parameter logic [2:0] Q_EN      = 3'b111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [2*COE_WIDTH-1:0]   in_p,
  input  logic [COE_WIDTH-1:0]     in_c,
  input  logic                     in_op,
  input  logic [1:0]               in_sel,
  output logic [COE_WIDTH-1:0]     out_r
);
  localparam int PW = 2 * COE_WIDTH + 1;
  // r < 3q needs two bits above the coefficient width.
  localparam int RW = COE_WIDTH + 2;

  logic [PW-1:0]        p1_q, p1_d;
  logic [1:0]           sel1_q, sel1_d, sel2_q, sel2_d;
  logic [RW-1:0]        r2_q, r2_d;
  logic [COE_WIDTH-1:0] out_q, out_d;

  logic [6:0]           k2;
  logic [RW-1:0]        mu2, qv2, qv3, r3;
  logic [PW-1:0]        est, q3;
  logic [PW+RW-1:0]     prod2;

  always_comb begin
    p1_d   = PW'(in_p) + ((in_op == OP_MULADD) ? PW'(in_c) : '0);
    sel1_d = in_sel;

    k2     = k_of(sel1_q, Q_EN);
    mu2    = RW'(mu_of(sel1_q, Q_EN));
    qv2    = RW'(q_of(sel1_q, Q_EN));
    est    = p1_q >> (k2 - 7'd1);
    prod2  = (PW+RW)'(est) * (PW+RW)'(mu2);
    q3     = PW'(prod2 >> (k2 + 7'd1));
    // Only the low RW bits of the remainder are needed; the true value is below 3q.
    r2_d   = RW'(p1_q) - RW'(q3) * qv2;
    sel2_d = sel1_q;

    qv3 = RW'(q_of(sel2_q, Q_EN));
    r3  = r2_q;
    if (r3 >= qv3) r3 = r3 - qv3;
    if (r3 >= qv3) r3 = r3 - qv3;
    out_d = qsel_err(sel2_q, Q_EN) ? '0 : COE_WIDTH'(r3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q   <= '0;
      sel1_q <= '0;
      r2_q   <= '0;
      sel2_q <= '0;
      out_q  <= '0;
    end else if (en) begin
      p1_q   <= p1_d;
      sel1_q <= sel1_d;
      r2_q   <= r2_d;
      sel2_q <= sel2_d;
      out_q  <= out_d;
    end
  end

  assign out_r = out_q;

endmodule

// File: rtl/mulred_pipe.sv
// rtl/mulred_pipe.sv - handshaked multi-lane (a*b [+c]) mod q pipeline with per-beat modulus select
module mulred_pipe
  import ntt_intt_pkg::*;
#(
  parameter int         COE_WIDTH = 39,
  parameter int         LANES     = 1,
  parameter int         PIP_LEVEL = 6,
  parameter int         TAG_WIDTH = 8,
  parameter logic [2:0] Q_EN      = 3'b111
) (
  input  logic          clk,
  input  logic          rst_n,
  mulred_pipe_if.slave  bus
);
  localparam int W   = COE_WIDTH;
  localparam int PWL = 2 * COE_WIDTH;
  // The lane owns the last three stages; everything before it is multiplier pipeline.
  localparam int MUL_STAGES = PIP_LEVEL - 3;

  logic                   stall, en;

  logic [LANES*PWL-1:0]   prod_q [MUL_STAGES];
  logic [LANES*PWL-1:0]   prod_d [MUL_STAGES];
  logic [LANES*W-1:0]     cm_q   [MUL_STAGES];
  logic [LANES*W-1:0]     cm_d   [MUL_STAGES];
  logic [1:0]             selm_q [MUL_STAGES];
  logic [1:0]             selm_d [MUL_STAGES];
  logic                   opm_q  [MUL_STAGES];
  logic                   opm_d  [MUL_STAGES];

  logic                   vld_q  [PIP_LEVEL];
  logic                   vld_d  [PIP_LEVEL];
  logic [TAG_WIDTH-1:0]   tag_q  [PIP_LEVEL];
  logic [TAG_WIDTH-1:0]   tag_d  [PIP_LEVEL];
  logic                   err_q  [PIP_LEVEL];
  logic                   err_d  [PIP_LEVEL];

  logic [LANES*W-1:0]     mulred;

  assign stall = vld_q[PIP_LEVEL-1] && !bus.i_ready;
  assign en    = !stall;

  always_comb begin
    for (int i = 0; i < MUL_STAGES; i++) begin
      prod_d[i] = '0;
      cm_d[i]   = '0;
      selm_d[i] = '0;
      opm_d[i]  = 1'b0;
    end
    for (int i = 0; i < PIP_LEVEL; i++) begin
      vld_d[i] = 1'b0;
      tag_d[i] = '0;
      err_d[i] = 1'b0;
    end

    for (int l = 0; l < LANES; l++) begin
      prod_d[0][l*PWL +: PWL] = PWL'(bus.i_a[l*W +: W]) * PWL'(bus.i_b[l*W +: W]);
    end
    cm_d[0]   = bus.i_c;
    selm_d[0] = bus.i_q_sel;
    opm_d[0]  = bus.i_op;
    for (int i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
      cm_d[i]   = cm_q[i-1];
      selm_d[i] = selm_q[i-1];
      opm_d[i]  = opm_q[i-1];
    end

    vld_d[0] = bus.i_valid;
    tag_d[0] = bus.i_tag;
    err_d[0] = bus.i_valid && qsel_err(bus.i_q_sel, Q_EN);
    for (int i = 1; i < PIP_LEVEL; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
      err_d[i] = err_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
        cm_q[i]   <= '0;
        selm_q[i] <= '0;
        opm_q[i]  <= 1'b0;
      end
      for (int i = 0; i < PIP_LEVEL; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else if (en) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_d[i];
        cm_q[i]   <= cm_d[i];
        selm_q[i] <= selm_d[i];
        opm_q[i]  <= opm_d[i];
      end
      for (int i = 0; i < PIP_LEVEL; i++) begin
        vld_q[i] <= vld_d[i];
        tag_q[i] <= tag_d[i];
        err_q[i] <= err_d[i];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    barrett_lane #(
      .COE_WIDTH (W),
      .Q_EN      (Q_EN)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .in_p   (prod_q[MUL_STAGES-1][l*PWL +: PWL]),
      .in_c   (cm_q[MUL_STAGES-1][l*W +: W]),
      .in_op  (opm_q[MUL_STAGES-1]),
      .in_sel (selm_q[MUL_STAGES-1]),
      .out_r  (mulred[l*W +: W])
    );
  end

  assign bus.o_ready  = en;
  assign bus.o_valid  = vld_q[PIP_LEVEL-1];
  assign bus.o_tag    = tag_q[PIP_LEVEL-1];
  assign bus.o_err    = err_q[PIP_LEVEL-1];
  assign bus.o_mulred = mulred;

endmodule

// File: tb/tb_mulred_pipe.sv
// tb/tb_mulred_pipe.sv - self-checking bench for mulred_pipe: directed vectors, random backpressure, reset
module tb_mulred_pipe;
  localparam int W = 39;
  localparam int L = 2;
  localparam int P = 6;
  localparam int T = 8;
  localparam logic [63:0] QV0 = 64'd4293918721;
  localparam logic [63:0] QV1 = 64'd8380417;
  localparam logic [63:0] QV2 = 64'd12289;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mulred_pipe_if #(.COE_WIDTH(W), .LANES(L), .TAG_WIDTH(T)) bus ();

  mulred_pipe #(
    .COE_WIDTH (W),
    .LANES     (L),
    .PIP_LEVEL (P),
    .TAG_WIDTH (T),
    .Q_EN      (3'b111)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]     sel;
    logic           op;
    logic [L*W-1:0] a, b, c;
    logic [T-1:0]   tag;
    logic [L*W-1:0] exp;
    logic           err;
  } vec_t;

  typedef struct {
    logic [L*W-1:0] exp;
    logic [T-1:0]   tag;
    logic           err;
    int             acc;
    bit             lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [L*W-1:0] pk(input logic [63:0] x1, input logic [63:0] x0);
    return {W'(x1), W'(x0)};
  endfunction

  function automatic logic [63:0] qval(input logic [1:0] sel);
    return (sel == 2'd0) ? QV0 : (sel == 2'd1) ? QV1 : QV2;
  endfunction

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [W-1:0] ref_red(input logic [1:0] sel, input logic op,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    logic [127:0] s;
    if (sel == 2'd3) return '0;
    s = 128'(a) * 128'(b) + (op ? 128'(c) : 128'd0);
    return W'(s % 128'(qval(sel)));
  endfunction

  function automatic vec_t mk(input logic [1:0] sel, input logic op, input logic [L*W-1:0] a,
                              input logic [L*W-1:0] b, input logic [L*W-1:0] c, input logic [T-1:0] tag,
                              input logic [L*W-1:0] exp, input logic err);
    vec_t v;
    v.sel = sel; v.op = op; v.a = a; v.b = b; v.c = c; v.tag = tag; v.exp = exp; v.err = err;
    return v;
  endfunction

  // Output-side scoreboard, handshake rule and stall-stability checks.
  logic [L*W-1:0] hold_r;
  logic [T-1:0]   hold_t;
  logic           hold_e;
  bit             prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("o_ready_rule", 128'(bus.o_ready), 128'(!(bus.o_valid && !bus.i_ready)));
      if (prev_stall) begin
        chk("stall_hold_valid", 128'(bus.o_valid), 128'd1);
        chk("stall_hold_data", 128'(bus.o_mulred), 128'(hold_r));
        chk("stall_hold_tag", 128'(bus.o_tag), 128'(hold_t));
        chk("stall_hold_err", 128'(bus.o_err), 128'(hold_e));
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      hold_r = bus.o_mulred;
      hold_t = bus.o_tag;
      hold_e = bus.o_err;
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: tag %0h data %0h appeared with nothing outstanding",
                   bus.o_tag, bus.o_mulred);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_tag", 128'(bus.o_tag), 128'(e.tag));
          chk("out_mulred", 128'(bus.o_mulred), 128'(e.exp));
          chk("out_err", 128'(bus.o_err), 128'(e.err));
          if (e.lat) chk("latency", 128'(cyc - e.acc), 128'(P));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input vec_t v, input bit lat);
    bit acc;
    exp_t e;
    acc = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_q_sel = v.sel;
    bus.i_op    = v.op;
    bus.i_a     = v.a;
    bus.i_b     = v.b;
    bus.i_c     = v.c;
    bus.i_tag   = v.tag;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        acc = 1'b1;
        e.exp = v.exp; e.tag = v.tag; e.err = v.err; e.acc = cyc; e.lat = lat;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 128'(acc), 128'd1);
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [T-1:0] tag, input int sel_max, input bit lat);
    vec_t v;
    logic [63:0] q;
    v.sel = 2'($urandom_range(0, sel_max));
    v.op  = 1'($urandom_range(0, 1));
    q = (v.sel == 2'd3) ? 64'h1_0000_0000 : qval(v.sel);
    for (int l = 0; l < L; l++) begin
      v.a[l*W +: W] = W'(64'($urandom) % q);
      v.b[l*W +: W] = W'(64'($urandom) % q);
      v.c[l*W +: W] = W'(64'($urandom) % q);
      v.exp[l*W +: W] = ref_red(v.sel, v.op, v.a[l*W +: W], v.b[l*W +: W], v.c[l*W +: W]);
    end
    v.tag = tag;
    v.err = (v.sel == 2'd3);
    send(v, lat);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk(name, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vt[9];

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_q_sel = '0;
    bus.i_op    = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_c     = '0;
    bus.i_tag   = '0;

    vt[0] = mk(2'd0, 1'b0, pk(QV0-1, 2), pk(QV0-1, 3), pk(0, 0), 8'h10, pk(1, 6), 1'b0);
    vt[1] = mk(2'd1, 1'b1, pk(QV1-1, 0), pk(1, 12345), pk(QV1-1, 0), 8'h11, pk(QV1-2, 0), 1'b0);
    vt[2] = mk(2'd0, 1'b0, pk(QV0-1, QV0-1), pk(QV0-1, QV0-1), pk(0, 0), 8'h20, pk(1, 1), 1'b0);
    vt[3] = mk(2'd1, 1'b0, pk(QV1-1, QV1-1), pk(QV1-1, QV1-1), pk(0, 0), 8'h21, pk(1, 1), 1'b0);
    vt[4] = mk(2'd2, 1'b0, pk(QV2-1, QV2-1), pk(QV2-1, QV2-1), pk(0, 0), 8'h22, pk(1, 1), 1'b0);
    vt[5] = mk(2'd3, 1'b0, pk(5, 7), pk(9, 11), pk(0, 0), 8'h23, pk(0, 0), 1'b1);
    vt[6] = mk(2'd0, 1'b0, pk(QV0-1, QV0-1), pk(QV0-1, QV0-1), pk(0, 0), 8'h24, pk(1, 1), 1'b0);
    vt[7] = mk(2'd2, 1'b1, pk(QV2-1, 100), pk(QV2-1, 200), pk(QV2-1, 0), 8'h25, pk(0, 7711), 1'b0);
    vt[8] = mk(2'd0, 1'b1, pk(QV0-1, 0), pk(QV0-1, 5), pk(QV0-1, 0), 8'h26, pk(0, 0), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_valid", 128'(bus.o_valid), 128'd0);
    chk("reset_o_mulred", 128'(bus.o_mulred), 128'd0);
    chk("reset_o_tag", 128'(bus.o_tag), 128'd0);
    chk("reset_o_err", 128'(bus.o_err), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_o_ready", 128'(bus.o_ready), 128'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) send(vt[i], 1'b1);
    idle();
    drain("drain_table");

    bp = 1'b1;
    for (int i = 0; i < 20; i++) send_rand(T'(i), 2, 1'b0);
    idle();
    drain("drain_backpressure");

    for (int i = 0; i < 150; i++) begin
      send_rand(T'(i + 32), 3, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    drain("drain_random");
    bp = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) send_rand(T'(8'hC0 + i), 2, 1'b1);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_o_valid", 128'(bus.o_valid), 128'd0);
    chk("midreset_o_mulred", 128'(bus.o_mulred), 128'd0);
    chk("midreset_o_err", 128'(bus.o_err), 128'd0);
    chk("midreset_o_tag", 128'(bus.o_tag), 128'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mk(2'd1, 1'b0, pk(3, 4), pk(5, 6), pk(0, 0), 8'h5A, pk(15, 24), 1'b0), 1'b1);
    idle();
    drain("drain_after_reset");
    repeat (20) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
